// File: rtl/mcm_pipe.sv
// rtl/mcm_pipe.sv - two-stage shift-add multiple-constant multiplier with valid/ready handshake
module mcm_pipe #(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*IN_W-1:0]  in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_p1,
  output logic [LANES*OUT_W-1:0] out_p2,
  output logic [1:0]             out_mode
);

  // Largest product is 58*(2^IN_W-1) negated or not, so IN_W+7 signed bits always suffice.
  if (OUT_W < IN_W + 7) begin : g_width_check
    $error("mcm_pipe: OUT_W must be at least IN_W+7");
  end

  logic                   r_s1_valid;
  logic                   r_s2_valid;
  logic [1:0]             r_s1_mode;
  logic [1:0]             r_s2_mode;
  // Per lane: index k holds x << k (k = 0 is the zero-extended sample itself).
  logic [OUT_W-1:0]       r_s1_t [LANES][7];
  logic [LANES*OUT_W-1:0] r_p1;
  logic [LANES*OUT_W-1:0] r_p2;
  logic [LANES*OUT_W-1:0] w_p1;
  logic [LANES*OUT_W-1:0] w_p2;
  logic [OUT_W-1:0]       w_x [LANES];
  logic                   w_s1_adv;
  logic                   w_s2_load;
  logic                   w_s1_load;

  // S2 can take a new beat when empty or when its current beat leaves this cycle.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_s1_load = in_valid && in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane_ext
    assign w_x[g] = {{(OUT_W-IN_W){1'b0}}, in_x[g*IN_W +: IN_W]};
  end

  // Stage 1: capture the sample, its shifted copies and the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < 7; k++) begin
          r_s1_t[i][k] <= '0;
        end
      end
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_mode <= in_mode;
        for (int i = 0; i < LANES; i++) begin
          for (int k = 0; k < 7; k++) begin
            r_s1_t[i][k] <= w_x[i] << k;
          end
        end
      end
    end
  end

  // Stage 2 combine: C1 is always negative, so P1 is the negated sum of its shift terms.
  always_comb begin
    w_p1 = '0;
    w_p2 = '0;
    for (int i = 0; i < LANES; i++) begin
      case (r_s1_mode)
        2'd0: begin
          // -3x, 7x = 8x - x
          w_p1[i*OUT_W +: OUT_W] = -(r_s1_t[i][1] + r_s1_t[i][0]);
          w_p2[i*OUT_W +: OUT_W] = r_s1_t[i][3] - r_s1_t[i][0];
        end
        2'd1: begin
          // -2x, 58x = 64x - 4x - 2x
          w_p1[i*OUT_W +: OUT_W] = -r_s1_t[i][1];
          w_p2[i*OUT_W +: OUT_W] = r_s1_t[i][6] - r_s1_t[i][2] - r_s1_t[i][1];
        end
        2'd2: begin
          // -4x, 54x = 32x + 16x + 4x + 2x
          w_p1[i*OUT_W +: OUT_W] = -r_s1_t[i][2];
          w_p2[i*OUT_W +: OUT_W] = r_s1_t[i][5] + r_s1_t[i][4] + r_s1_t[i][2] + r_s1_t[i][1];
        end
        default: begin
          // -6x, 46x = 32x + 16x - 2x
          w_p1[i*OUT_W +: OUT_W] = -(r_s1_t[i][2] + r_s1_t[i][1]);
          w_p2[i*OUT_W +: OUT_W] = r_s1_t[i][5] + r_s1_t[i][4] - r_s1_t[i][1];
        end
      endcase
    end
  end

  // Stage 2 register: outputs only change when a new beat moves in, so they hold while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= '0;
      r_p1       <= '0;
      r_p2       <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_p1      <= w_p1;
        r_p2      <= w_p2;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mode  = r_s2_mode;
  assign out_p1    = r_p1;
  assign out_p2    = r_p2;

endmodule

// File: tb/tb_mcm_pipe.sv
// tb/tb_mcm_pipe.sv - self-checking bench for mcm_pipe
module tb_mcm_pipe;
  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int C1 [4] = '{-3, -2, -4, -6};
  localparam int C2 [4] = '{7, 58, 54, 46};

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [1:0]             in_mode = '0;
  logic [LANES*IN_W-1:0]  in_x = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*OUT_W-1:0] out_p1;
  logic [LANES*OUT_W-1:0] out_p2;
  logic [1:0]             out_mode;

  always #5 clk = ~clk;

  mcm_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p1(out_p1), .out_p2(out_p2), .out_mode(out_mode)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]             mode;
    logic [LANES*OUT_W-1:0] p1;
    logic [LANES*OUT_W-1:0] p2;
    int                     acc;
  } beat_t;

  beat_t                  exp_q [$];
  logic [LANES*OUT_W-1:0] obs_p1 [$];
  logic [LANES*OUT_W-1:0] obs_p2 [$];
  logic                   stalled = 1'b0;
  logic [LANES*OUT_W-1:0] held_p1, held_p2;
  logic [1:0]             held_mode;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: plain integer multiplication by the mode's coefficient pair.
  function automatic beat_t model(input logic [1:0] m, input logic [LANES*IN_W-1:0] x, input int acc);
    beat_t b;
    b.mode = m;
    b.acc  = acc;
    b.p1   = '0;
    b.p2   = '0;
    for (int i = 0; i < LANES; i++) begin
      int xv;
      int v1;
      int v2;
      xv = int'(x[i*IN_W +: IN_W]);
      v1 = xv * C1[m];
      v2 = xv * C2[m];
      b.p1[i*OUT_W +: OUT_W] = v1[OUT_W-1:0];
      b.p2[i*OUT_W +: OUT_W] = v2[OUT_W-1:0];
    end
    return b;
  endfunction

  // Compare process: expected occupancy, handshake, data, ordering and stall stability every cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      chk("out_valid", out_valid, (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc));
      if (stalled) begin
        for (int i = 0; i < LANES; i++) begin
          chk($sformatf("hold_p1_l%0d", i), $signed(out_p1[i*OUT_W +: OUT_W]), $signed(held_p1[i*OUT_W +: OUT_W]));
          chk($sformatf("hold_p2_l%0d", i), $signed(out_p2[i*OUT_W +: OUT_W]), $signed(held_p2[i*OUT_W +: OUT_W]));
        end
        chk("hold_mode", out_mode, held_mode);
      end
      if (out_valid && exp_q.size() > 0) begin
        for (int i = 0; i < LANES; i++) begin
          chk($sformatf("p1_l%0d", i), $signed(out_p1[i*OUT_W +: OUT_W]), $signed(exp_q[0].p1[i*OUT_W +: OUT_W]));
          chk($sformatf("p2_l%0d", i), $signed(out_p2[i*OUT_W +: OUT_W]), $signed(exp_q[0].p2[i*OUT_W +: OUT_W]));
        end
        chk("mode", out_mode, exp_q[0].mode);
      end
      stalled   = out_valid && !out_ready;
      held_p1   = out_p1;
      held_p2   = out_p2;
      held_mode = out_mode;
      if (out_valid && out_ready) begin
        obs_p1.push_back(out_p1);
        obs_p2.push_back(out_p2);
        if (exp_q.size() > 0) exp_q.pop_front();
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_x, cyc));
    end
  end

  task automatic send(input logic [1:0] m, input logic [LANES*IN_W-1:0] x);
    int  t;
    logic acc;
    t = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = x;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: actual %0d required %0d", t, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual %0d required %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [LANES*IN_W-1:0] xv;
    logic [39:0]           pat;
    int e1 [4];
    int e2 [4];
    int m1 [4];
    int m2 [4];

    // Reset values
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p1", $signed(out_p1), 0);
    chk("rst_out_p2", $signed(out_p2), 0);
    chk("rst_out_mode", out_mode, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Coefficient sweep, x = 255 everywhere, back-to-back
    e1 = '{-765, -510, -1020, -1530};
    e2 = '{1785, 14790, 13770, 11730};
    obs_p1.delete();
    obs_p2.delete();
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) send(m[1:0], {LANES{8'd255}});
    idle(4);
    chk("sweep_count", obs_p1.size(), 4);
    for (int m = 0; m < 4 && m < obs_p1.size(); m++) begin
      for (int i = 0; i < LANES; i++) begin
        chk($sformatf("sweep_m%0d_p1_l%0d", m, i), $signed(obs_p1[m][i*OUT_W +: OUT_W]), e1[m]);
        chk($sformatf("sweep_m%0d_p2_l%0d", m, i), $signed(obs_p2[m][i*OUT_W +: OUT_W]), e2[m]);
      end
    end

    // Per-lane mix, mode 1, lanes (0, 1, 100, 255)
    m1 = '{0, -2, -200, -510};
    m2 = '{0, 58, 5800, 14790};
    obs_p1.delete();
    obs_p2.delete();
    send(2'd1, {8'd255, 8'd100, 8'd1, 8'd0});
    idle(3);
    chk("mix_count", obs_p1.size(), 1);
    if (obs_p1.size() > 0) begin
      for (int i = 0; i < LANES; i++) begin
        chk($sformatf("mix_p1_l%0d", i), $signed(obs_p1[0][i*OUT_W +: OUT_W]), m1[i]);
        chk($sformatf("mix_p2_l%0d", i), $signed(obs_p2[0][i*OUT_W +: OUT_W]), m2[i]);
      end
    end

    // Backpressure: 10 random beats against a fixed out_ready pattern
    obs_p1.delete();
    pat = 40'b1111_0110_1000_0011_1010_1100_1110_1001_1011_0101;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          xv = {$urandom, $urandom};
          send(2'($urandom_range(0, 3)), xv);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_count", obs_p1.size(), 10);

    // Full pipe, simultaneous push and pop
    out_ready = 1'b0;
    send(2'd0, {8'd10, 8'd20, 8'd30, 8'd40});
    send(2'd3, {8'd1, 8'd2, 8'd3, 8'd4});
    in_valid = 1'b1;
    in_mode  = 2'd2;
    in_x     = {8'd7, 8'd8, 8'd9, 8'd200};
    @(negedge clk);
    chk("full_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pushpop_in_ready", in_ready, 1);
    chk("pushpop_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("still_full_in_ready", in_ready, 0);
    chk("still_full_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(4);

    // Mid-stream reset with two beats in flight
    out_ready = 1'b0;
    send(2'd1, {8'd5, 8'd6, 8'd7, 8'd8});
    send(2'd2, {8'd9, 8'd10, 8'd11, 8'd12});
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_p1", $signed(out_p1), 0);
    idle(2);
    out_ready = 1'b1;
    rst_n = 1'b1;
    obs_p1.delete();
    idle(5);
    chk("no_stale_after_rst", obs_p1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
